resample_mac_scheduler: RTL

RESAMPLE_MAC_SCHEDULER -- requirements
Module: resample_mac_scheduler

---
 rtl/resample_pkg.sv | 18 +
 rtl/rr_arbiter.sv | 44 ++++
 rtl/resample_mac_scheduler.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/resample_pkg.sv
// Shared types and defaults for the polyphase resampler MAC scheduler.
package resample_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam int DEF_RATE_NUM = 274;
  localparam int DEF_RATE_DEN = 170;
  localparam int DEF_TAPS     = 8;
  localparam int PHASE_W      = 4;
  localparam int ACC_W        = 16;
  localparam int PEND_MAX     = 3;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant, search starts after the last granted index.
module rr_arbiter
  import resample_pkg::*;
#(
  parameter  int N  = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] i_req,
  input  logic         i_adv,
  output logic [N-1:0] o_gnt
);

  logic [IW-1:0] r_ptr;
  logic [IW-1:0] w_idx;
  logic [IW-1:0] w_cand;
  logic          w_found;
  int            j;

  always_comb begin
    o_gnt   = '0;
    w_idx   = '0;
    w_cand  = '0;
    w_found = 1'b0;
    j       = 0;
    for (int k = 1; k <= N; k++) begin
      j = int'(r_ptr) + k;
      if (j >= N) j = j - N;
      w_cand = IW'(j);
      if (!w_found && i_req[w_cand]) begin
        w_found       = 1'b1;
        o_gnt[w_cand] = 1'b1;
        w_idx         = w_cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset)                  r_ptr <= IW'(N - 1);
    else if (i_adv && w_found)  r_ptr <= w_idx;
  end

endmodule

// File: rtl/resample_mac_scheduler.sv
// Shares one MAC among NUM_CH channels: phase accumulator posts output requests,
// a round-robin FSM issues TAPS taps per request. Optional RESAMP_SCHED_STATUS_EN adds drop_count.
module resample_mac_scheduler
  import resample_pkg::*;
#(
  parameter  int NUM_CH   = 2,
  parameter  int TAPS     = DEF_TAPS,
  parameter  int RATE_NUM = DEF_RATE_NUM,
  parameter  int RATE_DEN = DEF_RATE_DEN,
  parameter  int PIPE_LAT = 2,
  localparam int TW       = (TAPS > 1) ? $clog2(TAPS) : 1,
  localparam int CW       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               tap_valid,
  output logic [TW-1:0]      tap_index,
  output logic [TW-1:0]      rd_offset,
  output logic [PHASE_W-1:0] phase_index,
  output logic [CW-1:0]      ch_sel,
  output logic               acc_clr,
  output logic               out_valid,
  output logic [CW-1:0]      out_ch,
  output logic               overflow
`ifdef RESAMP_SCHED_STATUS_EN
  , output logic [7:0]       drop_count
`endif
);

  localparam int SW = $clog2(TAPS + PIPE_LAT + 1);
  localparam int QW = ACC_W + PHASE_W;
  localparam logic [ACC_W-1:0] L_NUM = ACC_W'(RATE_NUM);
  localparam logic [ACC_W-1:0] L_DEN = ACC_W'(RATE_DEN);
  localparam logic [ACC_W-1:0] L_MAX = ACC_W'(RATE_NUM + RATE_DEN);
  localparam logic [QW-1:0]    L_DEN_Q = QW'(RATE_DEN);
  localparam logic [SW-1:0]    L_LAST_TAP = SW'(TAPS - 1);
  localparam logic [SW-1:0]    L_LAST_DRN = SW'((PIPE_LAT > 0) ? PIPE_LAT - 1 : 0);

  // ---------------- phase accumulator ----------------
  logic [ACC_W-1:0]   r_acc;
  logic [ACC_W-1:0]   w_acc_sub;
  logic [ACC_W:0]     w_acc_sum;
  logic [ACC_W-1:0]   w_acc_nx;
  logic               w_post;
  logic [QW-1:0]      w_phase_q;
  logic [PHASE_W-1:0] w_phase;

  always_comb begin
    w_post    = (r_acc >= L_DEN);
    w_acc_sub = w_post ? (r_acc - L_DEN) : r_acc;
    w_acc_sum = {1'b0, w_acc_sub} + {1'b0, (in_valid ? L_NUM : {ACC_W{1'b0}})};
    // Overload (ratio > 1 with back-to-back strobes) pins acc at its ceiling.
    w_acc_nx  = (w_acc_sum > {1'b0, L_MAX}) ? L_MAX : w_acc_sum[ACC_W-1:0];
    // Fractional phase = acc/DEN in [0,1); its top PHASE_W bits select the branch.
    w_phase_q = {r_acc, {PHASE_W{1'b0}}} / L_DEN_Q;
    w_phase   = (w_post || (|w_phase_q[QW-1:PHASE_W])) ? {PHASE_W{1'b1}}
                                                        : w_phase_q[PHASE_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) r_acc <= '0;
    else       r_acc <= w_acc_nx;
  end

  // ---------------- FSM ----------------
  state_t              r_state, w_state_nx;
  logic [SW-1:0]       r_step, w_step_nx;
  logic [CW-1:0]       r_ch;
  logic [PHASE_W-1:0]  r_phase;
  logic [NUM_CH-1:0]   w_req, w_gnt;
  logic [CW-1:0]       w_gnt_idx;
  logic                w_grant_en;

  rr_arbiter #(.N(NUM_CH)) u_arb (
    .clk   (clk),
    .reset (reset),
    .i_req (w_req),
    .i_adv (w_grant_en),
    .o_gnt (w_gnt)
  );

  always_comb begin
    w_gnt_idx = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (w_gnt[i]) w_gnt_idx = CW'(i);
  end

  always_comb begin
    w_state_nx = r_state;
    w_step_nx  = r_step;
    w_grant_en = 1'b0;
    tap_valid  = 1'b0;
    acc_clr    = 1'b0;
    out_valid  = 1'b0;
    case (r_state)
      S_IDLE: if (|w_gnt) begin
        w_grant_en = 1'b1;
        w_step_nx  = '0;
        w_state_nx = S_ISSUE;
      end
      S_ISSUE: begin
        tap_valid = 1'b1;
        acc_clr   = (r_step == '0);
        w_step_nx = r_step + 1'b1;
        if (r_step == L_LAST_TAP) begin
          w_step_nx  = '0;
          w_state_nx = (PIPE_LAT == 0) ? S_DONE : S_DRAIN;
        end
      end
      S_DRAIN: begin
        w_step_nx = r_step + 1'b1;
        if (r_step == L_LAST_DRN) begin
          w_step_nx  = '0;
          w_state_nx = S_DONE;
        end
      end
      S_DONE: begin
        out_valid  = 1'b1;
        w_state_nx = S_IDLE;
      end
      default: w_state_nx = S_IDLE;
    endcase
    tap_index   = tap_valid ? r_step[TW-1:0] : '0;
    rd_offset   = tap_index;
    ch_sel      = tap_valid ? r_ch : '0;
    phase_index = tap_valid ? r_phase : '0;
    out_ch      = out_valid ? r_ch : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_step  <= '0;
      r_ch    <= '0;
      r_phase <= '0;
    end else begin
      r_state <= w_state_nx;
      r_step  <= w_step_nx;
      if (w_grant_en) begin
        r_ch    <= w_gnt_idx;
        r_phase <= w_phase;
      end
    end
  end

  // ---------------- pending-request counters ----------------
  logic [NUM_CH-1:0][1:0] r_pend;
  logic [NUM_CH-1:0]      w_dec, w_drop;
  logic                   r_ovf;

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      w_req[i]  = |r_pend[i];
      w_dec[i]  = (r_state == S_DONE) && (r_ch == CW'(i));
      // A post that lands on the serving channel's DONE cycle nets to zero.
      w_drop[i] = w_post && !w_dec[i] && (r_pend[i] == 2'(PEND_MAX));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pend <= '0;
      r_ovf  <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (w_post && !w_dec[i] && !w_drop[i]) r_pend[i] <= r_pend[i] + 2'd1;
        else if (!w_post && w_dec[i])          r_pend[i] <= r_pend[i] - 2'd1;
      end
      r_ovf <= r_ovf | (|w_drop);
    end
  end

  assign overflow = r_ovf;

`ifdef RESAMP_SCHED_STATUS_EN
  logic [7:0] r_drops;
  logic [7:0] w_ndrop;
  logic [8:0] w_drop_sum;

  always_comb begin
    w_ndrop = '0;
    for (int i = 0; i < NUM_CH; i++) w_ndrop = w_ndrop + 8'(w_drop[i]);
    w_drop_sum = {1'b0, r_drops} + {1'b0, w_ndrop};
  end

  always_ff @(posedge clk) begin
    if (reset) r_drops <= '0;
    else       r_drops <= w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];
  end

  assign drop_count = r_drops;
`endif

endmodule
